// File: rtl/seq_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier_if
//  Description : Handshake and operand bundle between the pico-MIPS decoder /
//                register file and the sequential multiplier.
//                  start  - decoder MULT control, held while the instruction
//                           is presented
//                  a, b   - signed Q1.(WIDTH-1) operands
//                  stall  - freeze PC and register-file write enable
//                  done   - one-cycle result-valid pulse
//                  result - registered saturated product
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  // Datapath side (decoder / register file) drives the request.
  modport master (
    output start, a, b,
    input  stall, done, result
  );

  // Multiplier side.
  modport slave (
    input  start, a, b,
    output stall, done, result
  );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Multi-cycle signed fixed-point (Q1.(WIDTH-1)) shift-and-add
//                multiplier. Magnitudes are multiplied one bit per cycle so
//                the critical path is a single adder; the sign is applied and
//                the product saturated when the result is loaded.
//  Ports       : clk     - system clock, rising edge
//                n_reset - asynchronous active-low reset
//                bus     - seq_multiplier_if.slave (start, a, b in;
//                          stall, done, result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  wire logic        clk,
  input  wire logic        n_reset,
  seq_multiplier_if.slave  bus
);

  localparam int               c_cnt_w    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_max_pos  = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_ma;
  logic [WIDTH-1:0]     r_mb;
  logic [2*WIDTH-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_result;

  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [2*WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_mag;
  logic                 w_sat;
  logic [WIDTH-1:0]     w_res;

  // Magnitudes as unsigned WIDTH-bit values; the most negative operand maps
  // to 2^(WIDTH-1), which still fits.
  assign w_abs_a = bus.a[WIDTH-1] ? (~bus.a + c_one) : bus.a;
  assign w_abs_b = bus.b[WIDTH-1] ? (~bus.b + c_one) : bus.b;

  // One partial product per RUN cycle.
  assign w_pp       = {{WIDTH{1'b0}}, r_ma} << r_cnt;
  assign w_acc_next = r_acc + (r_mb[0] ? w_pp : '0);

  // Result is formed from the accumulator value being written on the final
  // RUN edge, so the last partial product is included.
  assign w_mag = w_acc_next[2*WIDTH-2:WIDTH-1];
  assign w_sat = !r_neg && (w_acc_next[2*WIDTH-1] || w_mag[WIDTH-1]);
  assign w_res = w_sat ? c_max_pos : (r_neg ? (~w_mag + c_one) : w_mag);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state  <= S_IDLE;
      r_ma     <= '0;
      r_mb     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // Bit 0 of |b| equals b[0], so the first partial product is
            // folded into the capture edge. The remaining WIDTH-1 bits take
            // WIDTH-1 RUN edges, keeping the instruction at WIDTH+1 cycles
            // with a fixed latency.
            r_ma    <= w_abs_a;
            r_mb    <= w_abs_b >> 1;
            r_neg   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_acc   <= bus.b[0] ? {{WIDTH{1'b0}}, w_abs_a} : '0;
            r_cnt   <= c_cnt_one;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + c_cnt_one;
          if (r_cnt == c_cnt_last) begin
            r_result <= w_res;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          // start is still high for the same instruction; ignore it.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall  = ((r_state == S_IDLE) && bus.start) || (r_state == S_RUN);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_multiplier
//  Description : Self-checking bench for seq_multiplier (WIDTH = 8): table of
//                signed Q1.7 products plus back-to-back, mid-RUN reset and
//                asynchronous reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

  localparam int WIDTH = 8;

  logic clk;
  logic n_reset;

  seq_multiplier_if #(.WIDTH(WIDTH)) mif ();

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (mif)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_result;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] held_result;
  int         cyc = 0;
  int         last_done_cyc = -1;
  int         prev_done_cyc = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mif.done === 1'b1) begin
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Presents one MULT instruction for its full 9 cycles, starting just after
  // a rising edge with the multiplier in IDLE. Operands are scrambled during
  // RUN; they must have no effect.
  task automatic do_mult(input logic [7:0] ta, input logic [7:0] tb,
                         input logic [7:0] exp, input string tag);
    mif.a     = ta;
    mif.b     = tb;
    mif.start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("%s stall c%0d", tag, k), 32'(mif.stall), 32'(k < 8));
      check($sformatf("%s done c%0d", tag, k), 32'(mif.done), 32'(k == 8));
      if (k < 8)
        check($sformatf("%s result held c%0d", tag, k), 32'(mif.result), 32'(held_result));
      else
        check($sformatf("%s result", tag), 32'(mif.result), 32'(exp));
      @(posedge clk);
      #1;
      if (k == 0) begin
        mif.a = ~ta;
        mif.b = tb ^ 8'h5A;
      end
    end
    mif.start   = 1'b0;
    held_result = exp;
  endtask

  vec_t vecs [6];

  initial begin
    int pulses;

    vecs[0] = '{a: 8'h40, b: 8'h40, exp_result: 8'h20}; //  0.5  * 0.5
    vecs[1] = '{a: 8'hC0, b: 8'h40, exp_result: 8'hE0}; // -0.5  * 0.5
    vecs[2] = '{a: 8'h80, b: 8'h7F, exp_result: 8'h81}; // -1 * 127/128 -> -127/128
    vecs[3] = '{a: 8'h00, b: 8'h80, exp_result: 8'h00}; //  0 * -1, zero stays zero
    vecs[4] = '{a: 8'h80, b: 8'h80, exp_result: 8'h7F}; // -1 * -1 saturates
    vecs[5] = '{a: 8'hA0, b: 8'hD0, exp_result: 8'h1C}; // -0.75 * -0.375 = 36/128 ... truncated

    // -0.75 * -0.375: |a|=96, |b|=48, 96*48=4608, >>7 = 36 = 0x24
    vecs[5].exp_result = 8'h24;

    held_result = 8'h00;
    n_reset     = 1'b0;
    mif.start   = 1'b0;
    mif.a       = 8'h00;
    mif.b       = 8'h00;

    #2;
    check("reset result", 32'(mif.result), 32'h00);
    check("reset done",   32'(mif.done),   32'h0);
    check("reset stall",  32'(mif.stall),  32'h0);

    @(posedge clk);
    #1;
    n_reset = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven products.
    for (int i = 0; i < 6; i++)
      do_mult(vecs[i].a, vecs[i].b, vecs[i].exp_result, $sformatf("vec%0d", i));

    // Back-to-back MULTs with no gap: 0.25 * 127/128 = 31.75/128 -> 0x1F.
    do_mult(8'h40, 8'h40, 8'h20, "b2b0");
    do_mult(8'h20, 8'h7F, 8'h1F, "b2b1");
    check("b2b done spacing", 32'(last_done_cyc - prev_done_cyc), 32'd9);

    // Reset after 4 RUN iterations: multiply discarded.
    mif.a     = 8'h80;
    mif.b     = 8'h7F;
    mif.start = 1'b1;
    repeat (5) @(posedge clk);  // E0 plus 4 RUN edges
    #3;
    n_reset   = 1'b0;
    mif.start = 1'b0;
    #1;
    check("midrun reset result", 32'(mif.result), 32'h00);
    check("midrun reset done",   32'(mif.done),   32'h0);
    check("midrun reset stall",  32'(mif.stall),  32'h0);
    held_result = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    pulses  = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mif.done === 1'b1) pulses++;
    end
    check("midrun no done pulse", 32'(pulses), 32'd0);
    @(posedge clk);
    #1;
    do_mult(8'h40, 8'h40, 8'h20, "rerun");

    // Asynchronous reset mid-cycle with a non-zero result present.
    #3;
    n_reset = 1'b0;
    #1;
    check("async reset result", 32'(mif.result), 32'h00);
    check("async reset done",   32'(mif.done),   32'h0);
    check("async reset stall",  32'(mif.stall),  32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
